dff_reg_arbiter: RTL and testbench
==================================

DFF_REG_ARBITER -- requirements
Module: dff_reg_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, setting the width of the shared storage register.
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the width of the write counter.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports i_req0 and i_req1, input, 1 bit each: write request from requester 0 and requester 1.
REQ-006 The block SHALL have ports i_data0 and i_data1, input, DATA_W each: write data from requester 0 and requester 1.
REQ-007 The block SHALL have ports o_gnt0 and o_gnt1, output, 1 bit each: grant to the requester; at most one is high at a time.
REQ-008 The block SHALL have ports o_ack0 and o_ack1, output, 1 bit each: one-cycle write-done pulse.
REQ-009 The block SHALL have port o_q, output, DATA_W: the stored register value.
REQ-010 The block SHALL have port o_qbar, output, DATA_W: the bitwise inverse of o_q at all times.
REQ-011 The block SHALL have port o_wr_count, output, CNT_W: count of completed writes; present only with DFF_ARB_STATS_EN.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, GRANT0, GRANT1 and ACK.
REQ-013 In IDLE, a rising edge with exactly one request asserted SHALL move the FSM to the matching GRANTx state.
REQ-014 In IDLE with both requests asserted, the FSM SHALL grant the requester not served last (round-robin); after reset, requester 0 wins.
REQ-015 o_gntx SHALL be high exactly while the FSM is in GRANTx (Moore output).
REQ-016 In GRANTx with i_reqx high, the next edge SHALL load i_datax into o_q, update the last-served pointer to x, and enter ACK.
REQ-017 In ACK, o_ackx SHALL be high for exactly one cycle, for the requester just written; the next edge SHALL return the FSM to IDLE.
REQ-018 Write latency SHALL be: request sampled at edge k, grant high for cycle k..k+1, o_q updated at edge k+1, ack high for cycle k+1..k+2.
REQ-019 Each write SHALL occupy 3 cycles (IDLE, GRANT, ACK), so a continuously requesting pair alternates 0,1,0,1 with no starvation.
REQ-020 If i_reqx drops while in GRANTx (abort), the next edge SHALL return to IDLE with no o_q change, no ack, and no pointer update.
REQ-021 A request arriving during GRANT or ACK of the other requester SHALL wait and be arbitrated in the next IDLE cycle.
REQ-022 o_q SHALL change only on a completed write (REQ-016) or on reset.

Reset
REQ-023 On i_rst high at a rising edge, the FSM SHALL enter IDLE with o_q = 0, o_qbar = all ones, o_gnt0/1 = 0, o_ack0/1 = 0, pointer favouring requester 0, and o_wr_count = 0.
REQ-024 Reset SHALL take priority over any in-flight grant or ack; an interrupted write SHALL leave o_q at 0 and produce no ack.
REQ-025 Requests held through reset SHALL be arbitrated starting at the first edge after i_rst deasserts.

Configuration
REQ-026 With macro DFF_ARB_STATS_EN defined, the block SHALL provide o_wr_count, which increments by 1 at each completed write (REQ-016) and wraps from 2^CNT_W-1 to 0.
REQ-027 Without DFF_ARB_STATS_EN, the o_wr_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then i_req0=1 and i_data0=8'hA5 held: the bench SHALL see o_gnt0 for 1 cycle, o_q=8'hA5 and o_qbar=8'h5A after edge 2, and o_ack0 pulsed for 1 cycle.
REQ-029 Both requests held, i_data0=8'h11 and i_data1=8'h22: the bench SHALL see o_q take the values 11, 22, 11, 22 at 3-cycle intervals, with acks alternating.
REQ-030 i_req1=1, then drop it during GRANT1: the bench SHALL see the FSM return to IDLE, o_q unchanged, no o_ack1, and the next simultaneous request go to requester 1.
REQ-031 i_rst asserted during GRANT0 after a prior write of 8'h3C: the bench SHALL see o_q=0, grant and ack low, and requester 0 win the next simultaneous request.
REQ-032 With DFF_ARB_STATS_EN and CNT_W=2, five writes: the bench SHALL see o_wr_count step 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_reg_arbiter
//  Purpose  : Two-requester round-robin arbiter guarding one shared DATA_W
//             storage register. Each write runs IDLE -> GRANTx -> ACK, which
//             is three cycles. A requester that drops its request while
//             granted aborts the write; nothing is stored and no ack is sent.
//  Ports    : i_clk             - clock; all state changes on its rising edge
//             i_rst             - synchronous active-high reset
//             i_req0 / i_req1   - write requests
//             i_data0 / i_data1 - write data, DATA_W bits each
//             o_gnt0 / o_gnt1   - grant, high while in GRANT0 / GRANT1
//             o_ack0 / o_ack1   - one-cycle write-done pulse
//             o_q / o_qbar      - stored value and its bitwise inverse
//             o_wr_count        - completed-write counter, CNT_W bits; this
//                                 port exists only when DFF_ARB_STATS_EN is
//                                 defined
//  Options  : `define DFF_ARB_STATS_EN to add the write counter
//  Revision : 1.0 - initial release
// ============================================================================
module dff_reg_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_data0,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_q,
  output logic [DATA_W-1:0] o_qbar
`ifdef DFF_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  // Last-served requester. Reset loads 1, so requester 0 wins the first tie.
  // The ack decode in ACK also reads this pointer, because a completed write
  // always updates it just before ACK is entered.
  logic                r_last;
  logic [DATA_W-1:0]   r_q;
  logic                w_wr0;
  logic                w_wr1;

  // A write completes when the granted requester still holds its request.
  assign w_wr0 = (r_state == GRANT0) && i_req0;
  assign w_wr1 = (r_state == GRANT1) && i_req1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr0) begin
        r_q    <= i_data0;
        r_last <= 1'b0;
      end else if (w_wr1) begin
        r_q    <= i_data1;
        r_last <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_gnt0      = 1'b0;
    o_gnt1      = 1'b0;
    o_ack0      = 1'b0;
    o_ack1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req0 && i_req1) begin
          w_state_nxt = r_last ? GRANT0 : GRANT1;
        end else if (i_req0) begin
          w_state_nxt = GRANT0;
        end else if (i_req1) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        o_gnt0      = 1'b1;
        w_state_nxt = i_req0 ? ACK : IDLE;
      end
      GRANT1: begin
        o_gnt1      = 1'b1;
        w_state_nxt = i_req1 ? ACK : IDLE;
      end
      ACK: begin
        o_ack0      = ~r_last;
        o_ack1      = r_last;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

`ifdef DFF_ARB_STATS_EN
  logic [CNT_W-1:0] r_wr_count;

  // The counter wraps naturally from all-ones back to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_count <= '0;
    end else if (w_wr0 || w_wr1) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign o_wr_count = r_wr_count;
`else
  // With the counter absent, CNT_W only has to be a legal width.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_reg_arbiter
//  Purpose  : Directed self-checking bench for dff_reg_arbiter. It covers
//             reset, round-robin alternation, a single write, an abort,
//             and a reset that lands during a grant. When DFF_ARB_STATS_EN
//             is defined it also checks that o_wr_count wraps at CNT_W = 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dff_reg_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, ack0, ack1;
  logic [7:0] q, qbar;
`ifdef DFF_ARB_STATS_EN
  logic [1:0] wr_count;
`endif

  int passes = 0;
  int total  = 0;

  dff_reg_arbiter #(.DATA_W(8), .CNT_W(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_data0 (data0),
    .i_data1 (data1),
    .o_gnt0  (gnt0),
    .o_gnt1  (gnt1),
    .o_ack0  (ack0),
    .o_ack1  (ack1),
    .o_q     (q),
    .o_qbar  (qbar)
`ifdef DFF_ARB_STATS_EN
    ,
    .o_wr_count (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away
  // from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_io(input string tag, input logic g0, input logic g1,
                        input logic a0, input logic a1, input logic [7:0] qe);
    chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    chk({tag, ".ack0"}, {31'd0, ack0}, {31'd0, a0});
    chk({tag, ".ack1"}, {31'd0, ack1}, {31'd0, a1});
    chk({tag, ".q"},    {24'd0, q},    {24'd0, qe});
    chk({tag, ".qbar"}, {24'd0, qbar}, {24'd0, ~qe});
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk_io("reset", 0, 0, 0, 0, 8'h00);
`ifdef DFF_ARB_STATS_EN
    chk("reset.cnt", {30'd0, wr_count}, 32'd0);
`endif

    // Both requesters held: writes alternate 0,1,0,1 at 3-cycle intervals.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i % 2 == 0) chk_io("rr.grant", 1, 0, 0, 0, (i == 0) ? 8'h00 : 8'h22);
      else            chk_io("rr.grant", 0, 1, 0, 0, 8'h11);
      step();
      if (i % 2 == 0) chk_io("rr.ack", 0, 0, 1, 0, 8'h11);
      else            chk_io("rr.ack", 0, 0, 0, 1, 8'h22);
`ifdef DFF_ARB_STATS_EN
      chk("rr.cnt", {30'd0, wr_count}, (i == 3) ? 32'd0 : i + 1);
`endif
      step();
      chk_io("rr.idle", 0, 0, 0, 0, (i % 2 == 0) ? 8'h11 : 8'h22);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Single requester 0 writes A5.
    req0 = 1'b1; data0 = 8'hA5;
    step();
    chk_io("single.grant", 1, 0, 0, 0, 8'h22);
    step();
    chk_io("single.ack", 0, 0, 1, 0, 8'hA5);
`ifdef DFF_ARB_STATS_EN
    chk("single.cnt", {30'd0, wr_count}, 32'd1);
`endif
    req0 = 1'b0;
    step();
    chk_io("single.idle", 0, 0, 0, 0, 8'hA5);

    // Requester 1 aborts while granted.
    req1 = 1'b1; data1 = 8'h77;
    step();
    chk_io("abort.grant", 0, 1, 0, 0, 8'hA5);
    req1 = 1'b0;
    step();
    chk_io("abort.idle", 0, 0, 0, 0, 8'hA5);
    step();
    chk_io("abort.noack", 0, 0, 0, 0, 8'hA5);
    // The pointer still favours requester 1, so it wins the tie.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h44;
    step();
    chk_io("abort.tie", 0, 1, 0, 0, 8'hA5);
    step();
    chk_io("abort.ack", 0, 0, 0, 1, 8'h77);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk_io("abort.done", 0, 0, 0, 0, 8'h77);

    // Write 3C, then assert reset during the next grant.
    req0 = 1'b1; data0 = 8'h3C;
    step();
    chk_io("rst.w.grant", 1, 0, 0, 0, 8'h77);
    step();
    chk_io("rst.w.ack", 0, 0, 1, 0, 8'h3C);
    req0 = 1'b0;
    step();
    req0 = 1'b1; data0 = 8'h99;
    step();
    chk_io("rst.grant", 1, 0, 0, 0, 8'h3C);
    rst = 1'b1; req1 = 1'b1; data1 = 8'h55;
    step();
    chk_io("rst.hit", 0, 0, 0, 0, 8'h00);
`ifdef DFF_ARB_STATS_EN
    chk("rst.cnt", {30'd0, wr_count}, 32'd0);
`endif
    step();
    chk_io("rst.hold", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    step();
    chk_io("rst.tie", 1, 0, 0, 0, 8'h00);
    step();
    chk_io("rst.ack", 0, 0, 1, 0, 8'h99);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk_io("rst.done", 0, 0, 0, 0, 8'h99);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
